// File: rtl/cache_mon_pkg.sv
// Cache FSM state encoding and trace-entry field layout shared by the cache
// FSM and cache_trace_mon.
package cache_mon_pkg;

    localparam int STATE_W_DEF = 3;

    typedef enum logic [STATE_W_DEF-1:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_EVICT = 3'd4
    } cache_state_e;

    // Entry layout, LSB first: way_hit_last, new_state, prev_state, timestamp
    localparam int WAY_LSB = 0;

    function automatic int new_lsb(input int ways);
        return ways;
    endfunction

    function automatic int prev_lsb(input int ways, input int sw);
        return ways + sw;
    endfunction

    function automatic int ts_lsb(input int ways, input int sw);
        return ways + 2 * sw;
    endfunction

    function automatic int entry_w(input int ts_w, input int sw, input int ways);
        return ts_w + 2 * sw + ways;
    endfunction

endpackage

// File: rtl/cache_trace_mon_fifo.sv
// trace_fifo: circular trace buffer with occupancy level and registered
// single-entry read port (data and valid one cycle after the request).
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_req,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign pop   = rd_req && !empty;
    // A pop in the same cycle frees the slot the write lands in
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            level   <= '0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= pop;
            if (pop) begin
                rd_data <= mem[rp];
                rp      <= rp + AW'(1);
            end
            if (push) begin
                wp <= wp + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: rtl/cache_trace_mon.sv
// Cache FSM trace monitor: timestamps state transitions into a trace buffer
// and counts per-way hits/misses when CACHE_MON_COUNTERS_EN is defined.
module cache_trace_mon
    import cache_mon_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int STATE_W = STATE_W_DEF,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [STATE_W-1:0]            fsm_state,
    input  logic                          lookup_vld,
    input  logic [WAYS-1:0]               way_hit,
    input  logic                          arm,
    input  logic                          rd_req,
    output logic                          rd_vld,
    output logic [TS_W+2*STATE_W+WAYS-1:0] rd_data,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic                          multi_hit,
    output logic [WAYS*CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);

    localparam int EW       = entry_w(TS_W, STATE_W, WAYS);
    localparam int NEW_LSB  = new_lsb(WAYS);
    localparam int PREV_LSB = prev_lsb(WAYS, STATE_W);
    localparam int TS_LSB   = ts_lsb(WAYS, STATE_W);

    logic [TS_W-1:0]    ts;
    logic [STATE_W-1:0] prev_state;
    logic [WAYS-1:0]    way_hit_last;
    logic               arm_q;
    logic               arm_rise;
    logic               transition;
    logic               capture;
    logic               drop;
    logic               overflow_q;
    logic [EW-1:0]      entry;

    assign arm_rise   = arm && !arm_q;
    assign transition = (fsm_state != prev_state);
    assign capture    = arm && transition;
    assign overflow   = overflow_q;

    always_comb begin
        entry = '0;
        entry[WAY_LSB  +: WAYS]    = way_hit_last;
        entry[NEW_LSB  +: STATE_W] = fsm_state;
        entry[PREV_LSB +: STATE_W] = prev_state;
        entry[TS_LSB   +: TS_W]    = ts;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts           <= '0;
            prev_state   <= '0;
            way_hit_last <= '0;
            arm_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ts         <= ts + TS_W'(1);
            prev_state <= fsm_state;
            arm_q      <= arm;
            if (lookup_vld) begin
                way_hit_last <= way_hit;
            end
            // A drop in the re-arm cycle still counts as an overflow
            overflow_q <= (overflow_q && !arm_rise) || drop;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (entry),
        .rd_req  (rd_req),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .level   (level),
        .drop    (drop)
    );

`ifdef CACHE_MON_COUNTERS_EN
    logic [CNT_W-1:0] hits [WAYS];
    logic [CNT_W-1:0] misses;
    logic             multi_q;
    logic             multi_now;

    // More than one bit set iff clearing the lowest set bit leaves something
    assign multi_now = lookup_vld &&
                       ((way_hit & (way_hit - WAYS'(1))) != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                hits[i] <= '0;
            end
            misses  <= '0;
            multi_q <= 1'b0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (lookup_vld && way_hit[i] && (hits[i] != '1)) begin
                    hits[i] <= hits[i] + CNT_W'(1);
                end
            end
            if (lookup_vld && (way_hit == '0) && (misses != '1)) begin
                misses <= misses + CNT_W'(1);
            end
            multi_q <= (multi_q && !arm_rise) || multi_now;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_pack
        assign hit_cnt[g*CNT_W +: CNT_W] = hits[g];
    end

    assign miss_cnt  = misses;
    assign multi_hit = multi_q;
`else
    assign hit_cnt   = '0;
    assign miss_cnt  = '0;
    assign multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cache_trace_mon.sv
// Scoreboard bench for cache_trace_mon: read expectations are queued when a
// pop is issued and checked by a negedge monitor when rd_vld appears.
module tb_cache_trace_mon;
    import cache_mon_pkg::*;

`ifdef CACHE_MON_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  fsm_state = 3'd0;
    logic        lookup_vld = 1'b0;
    logic [3:0]  way_hit = 4'd0;
    logic        arm = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_vld;
    logic [25:0] rd_data;
    logic [4:0]  level;
    logic        overflow;
    logic        multi_hit;
    logic [127:0] hit_cnt;
    logic [31:0] miss_cnt;

    logic        s_lookup_vld = 1'b0;
    logic [3:0]  s_way_hit = 4'd0;
    logic [2:0]  s_fsm = 3'd0;
    logic        s_arm = 1'b0;
    logic        s_rd_req = 1'b0;
    logic        s_rd_vld;
    logic [25:0] s_rd_data;
    logic [4:0]  s_level;
    logic        s_overflow;
    logic        s_multi;
    logic [15:0] s_hit_cnt;
    logic [3:0]  s_miss_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [25:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [25:0] model[$];

    cache_trace_mon u_dut (
        .clk(clk), .reset(reset), .fsm_state(fsm_state),
        .lookup_vld(lookup_vld), .way_hit(way_hit), .arm(arm),
        .rd_req(rd_req), .rd_vld(rd_vld), .rd_data(rd_data),
        .level(level), .overflow(overflow), .multi_hit(multi_hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_trace_mon #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .fsm_state(s_fsm),
        .lookup_vld(s_lookup_vld), .way_hit(s_way_hit), .arm(s_arm),
        .rd_req(s_rd_req), .rd_vld(s_rd_vld), .rd_data(s_rd_data),
        .level(s_level), .overflow(s_overflow), .multi_hit(s_multi),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] ent(input int ts, input logic [2:0] p,
                                        input logic [2:0] n,
                                        input logic [3:0] w);
        logic [15:0] t;
        t = 16'(ts);
        return {t, p, n, w};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_vld_unexpected: got rd_data %0h at cyc %0d expected no pulse",
                         rd_data, cyc);
            end else begin
                e = sb.pop_front();
                check("rd_data", 64'(rd_data), 64'(e.data));
                check("rd_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic do_pop(input logic [25:0] e);
        sb.push_back('{e, cyc + 1});
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic at_cyc(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  prev;
        logic [2:0]  nxt;
        logic [25:0] e_old;
        logic [25:0] e_new;
        int          c;

        @(negedge clk);
        @(negedge clk);
        check("rst_level", 64'(level), 64'd0);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_counters", 64'(hit_cnt[63:0] | hit_cnt[127:64]) |
              64'(miss_cnt) | 64'(multi_hit), 64'd0);
        reset = 1'b0;
        arm = 1'b1;

        // IDLE->READ at ts 5, READ->IDLE at ts 9
        at_cyc(5);
        fsm_state = ST_READ;
        at_cyc(9);
        fsm_state = ST_IDLE;
        @(negedge clk);
        check("two_level", 64'(level), 64'd2);
        do_pop(ent(5, ST_IDLE, ST_READ, 4'd0));
        do_pop(ent(9, ST_READ, ST_IDLE, 4'd0));
        @(negedge clk);
        check("drained_level", 64'(level), 64'd0);

        // pop on empty buffer is ignored
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        check("empty_level", 64'(level), 64'd0);

        // 17 transitions, no pops: last one dropped
        prev = ST_IDLE;
        for (int k = 0; k < 17; k++) begin
            nxt = 3'((k + 1) % 5);
            fsm_state = nxt;
            if (k < 16) model.push_back(ent(cyc, prev, nxt, 4'd0));
            prev = nxt;
            @(negedge clk);
        end
        check("full_level", 64'(level), 64'd16);
        check("overflow_set", 64'(overflow), 64'd1);

        // re-arm clears overflow, keeps contents
        arm = 1'b0;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        check("rearm_overflow", 64'(overflow), 64'd0);
        check("rearm_level", 64'(level), 64'd16);

        // capture and pop together while full
        c = cyc;
        fsm_state = ST_FILL;
        e_new = ent(c, prev, ST_FILL, 4'd0);
        e_old = model.pop_front();
        model.push_back(e_new);
        do_pop(e_old);
        check("simul_level", 64'(level), 64'd16);
        check("simul_overflow", 64'(overflow), 64'd0);
        while (model.size() > 0) do_pop(model.pop_front());
        @(negedge clk);
        check("drain16_level", 64'(level), 64'd0);

        // lookups 0001, 0100, 0000, 0110
        lookup_vld = 1'b1;
        way_hit = 4'b0001;
        @(negedge clk);
        way_hit = 4'b0100;
        @(negedge clk);
        way_hit = 4'b0000;
        @(negedge clk);
        way_hit = 4'b0110;
        @(negedge clk);
        lookup_vld = 1'b0;
        way_hit = 4'b1111;
        @(negedge clk);
        check("hit_way0", 64'(hit_cnt[31:0]), CNT_EN ? 64'd1 : 64'd0);
        check("hit_way1", 64'(hit_cnt[63:32]), CNT_EN ? 64'd1 : 64'd0);
        check("hit_way2", 64'(hit_cnt[95:64]), CNT_EN ? 64'd2 : 64'd0);
        check("hit_way3", 64'(hit_cnt[127:96]), 64'd0);
        check("miss_cnt", 64'(miss_cnt), CNT_EN ? 64'd1 : 64'd0);
        check("multi_hit", 64'(multi_hit), CNT_EN ? 64'd1 : 64'd0);

        // way_hit_last lands in the next entry
        c = cyc;
        fsm_state = ST_READ;
        @(negedge clk);
        check("whl_level", 64'(level), 64'd1);
        do_pop(ent(c, ST_FILL, ST_READ, 4'b0110));

        // re-arm clears multi_hit; counting continues while disarmed
        arm = 1'b0;
        lookup_vld = 1'b1;
        way_hit = 4'b1000;
        @(negedge clk);
        lookup_vld = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        check("rearm_multi", 64'(multi_hit), 64'd0);
        check("disarmed_way3", 64'(hit_cnt[127:96]), CNT_EN ? 64'd1 : 64'd0);
        check("kept_way2", 64'(hit_cnt[95:64]), CNT_EN ? 64'd2 : 64'd0);

        // 4-bit counters saturate at 15
        s_lookup_vld = 1'b1;
        s_way_hit = 4'b0001;
        for (int k = 0; k < 20; k++) @(negedge clk);
        s_lookup_vld = 1'b0;
        @(negedge clk);
        check("sat_way0", 64'(s_hit_cnt[3:0]), CNT_EN ? 64'd15 : 64'd0);
        check("sat_miss", 64'(s_miss_cnt), 64'd0);
        check("sat_idle", 64'(s_level) | 64'(s_overflow) | 64'(s_multi) |
              64'(s_rd_vld) | 64'(s_rd_data), 64'd0);

        // reset between rd_req and rd_vld
        fsm_state = ST_IDLE;
        @(negedge clk);
        check("pre_rst_level", 64'(level), 64'd1);
        rd_req = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("midrd_rd_vld", 64'(rd_vld), 64'd0);
        check("midrd_rd_data", 64'(rd_data), 64'd0);
        check("midrd_level", 64'(level), 64'd0);
        check("midrd_flags", 64'(overflow) | 64'(multi_hit), 64'd0);
        check("midrd_counters", 64'(hit_cnt[63:0] | hit_cnt[127:64]) |
              64'(miss_cnt), 64'd0);
        check("midrd_sat", 64'(s_hit_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_level", 64'(level), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_trace_mon.md
CACHE_TRACE_MON -- requirements
Module: cache_trace_mon

Interface
REQ-001 SHALL have parameter WAYS, default 4: number of cache ways monitored.
REQ-002 SHALL have parameter STATE_W, default 3: width of the cache FSM state code.
REQ-003 SHALL have parameter DEPTH, default 16 (power of two, >=2): number of trace buffer entries.
REQ-004 SHALL have parameter TS_W, default 16: width of the trace timestamp.
REQ-005 SHALL have parameter CNT_W, default 32: width of each event counter.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port fsm_state  in  STATE_W  current cache FSM state.
REQ-009 SHALL have port lookup_vld  in  1  lookup result valid this cycle.
REQ-010 SHALL have port way_hit  in  WAYS  way-hit vector, qualified by lookup_vld.
REQ-011 SHALL have port arm  in  1  level-high enable for trace capture.
REQ-012 SHALL have port rd_req  in  1  single-cycle request to pop one trace entry.
REQ-013 SHALL have port rd_vld  out  1  one-cycle pulse marking rd_data valid.
REQ-014 SHALL have port rd_data  out  TS_W+2*STATE_W+WAYS  fields {timestamp, prev_state, new_state, way_hit_last}.
REQ-015 SHALL have port level  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 SHALL have port overflow  out  1  sticky flag: an entry was dropped.
REQ-017 SHALL have port multi_hit  out  1  sticky flag: lookup_vld seen with more than one way_hit bit set.
REQ-018 SHALL have port hit_cnt  out  WAYS*CNT_W  per-way hit counters, way 0 in the LSBs.
REQ-019 SHALL have port miss_cnt  out  CNT_W  miss counter.

Function
REQ-020 SHALL run a free-running TS_W timestamp counter, incrementing every cycle and wrapping from all-ones to 0.
REQ-021 SHALL register fsm_state each cycle as prev_state; a transition is a cycle where fsm_state != prev_state.
REQ-022 SHALL register the way_hit of the most recent lookup_vld cycle as way_hit_last.
REQ-023 SHALL, while arm=1 and a transition occurs, write {timestamp, prev_state, fsm_state, way_hit_last} into the circular buffer at the write pointer.
REQ-024 SHALL, on a transition while level==DEPTH and no pop occurs in the same cycle, drop the entry and set overflow.
REQ-025 SHALL, on rd_req with level>0, drive rd_data from the read pointer and pulse rd_vld exactly one cycle later (latency 1).
REQ-026 SHALL ignore rd_req when level==0: no rd_vld pulse, pointers unchanged.
REQ-027 SHALL, on a simultaneous capture and pop when full, accept both; level stays DEPTH and overflow is not set.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL clear overflow and multi_hit on a rising edge of arm; buffer contents and level are kept.
REQ-030 SHALL, on lookup_vld, increment hit_cnt[i] for each set way_hit bit i, increment miss_cnt when way_hit==0, and set multi_hit when popcount(way_hit)>1.
REQ-031 SHALL saturate every counter at all-ones; counting is independent of arm.

Reset
REQ-032 SHALL, on reset assertion, asynchronously clear pointers, level, timestamp, prev_state, way_hit_last, rd_vld, rd_data, overflow, multi_hit and all counters to 0.
REQ-033 SHALL, on reset mid-read, drop the pending rd_vld; buffer RAM contents are don't-care after reset.

Configuration
REQ-034 SHALL, with CACHE_MON_COUNTERS_EN defined, implement REQ-030/031; without it, hit_cnt, miss_cnt and multi_hit SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-035 SHALL take the FSM state encoding and the trace-entry field offsets from a shared package cache_mon_pkg, also used by the cache FSM.
REQ-036 SHALL instantiate one sub-module, trace_fifo (DEPTH x entry width, circular, with level), for buffer storage and pointers.

Verification
REQ-037 SHALL cover: arm=1, FSM IDLE->READ->IDLE at ts 5,9 -> level=2; pops return {5,IDLE,READ} then {9,READ,IDLE}, each with rd_vld one cycle after rd_req.
REQ-038 SHALL cover: DEPTH=16, 17 transitions with no pops -> level=16, overflow=1; the first pop returns the oldest entry.
REQ-039 SHALL cover: full buffer, transition and rd_req in the same cycle -> level stays 16, overflow stays 0.
REQ-040 SHALL cover: lookups with way_hit 0001, 0100, 0000, 0110 -> hit_cnt way0=1, way1=1, way2=2; miss_cnt=1; multi_hit=1.
REQ-041 SHALL cover: rd_req on empty buffer -> no rd_vld; reset asserted between rd_req and rd_vld -> no rd_vld, all outputs 0.
REQ-042 SHALL cover: CNT_W=4 with 20 way-0 hits -> hit_cnt way0 holds at 15; without CACHE_MON_COUNTERS_EN, all counters read 0.
